// File: rtl/ps2_writer.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then shifts one
// command byte (LSB first, odd parity, stop) out on device-generated clock edges and checks the ACK.
module ps2_writer #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_low,
  output logic       o_ps2_data_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAITIDLE
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          data_low_q, data_low_d;
  logic [8:0]    shift_q, shift_d;
  logic          fall, timing, timeout;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Synchronizers idle high so a released bus never looks like an edge after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= i_ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= i_ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timing  = (state_q == S_RELEASE) || (state_q == S_SEND) ||
                   (state_q == S_ACK) || (state_q == S_WAITIDLE);
  assign timeout = timing && (to_cnt_q == TO_MAX);

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = timing ? (to_cnt_q + TW'(1)) : to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_low_d = data_low_q;
    shift_d    = shift_q;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_data_valid) begin
          shift_d    = {odd_parity(i_data), i_data};
          inh_cnt_d  = '0;
          to_cnt_d   = '0;
          bit_cnt_d  = '0;
          data_low_d = 1'b0;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_low_d = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      S_RELEASE: begin
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // Ones shift in from the top, so edge 10 naturally releases data for the stop bit.
        if (fall) begin
          bit_cnt_d  = bit_cnt_q + 4'd1;
          data_low_d = ~shift_q[0];
          shift_d    = {1'b1, shift_q[8:1]};
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!dat_s2_q) begin
            state_d = S_WAITIDLE;
          end else begin
            o_error = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAITIDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      o_done     = 1'b0;
      o_error    = 1'b1;
      data_low_d = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      data_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_low_q <= data_low_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  // Line enables decode from state so an async reset drops them without a clock edge.
  assign o_ready        = (state_q == S_IDLE);
  assign o_busy         = (state_q != S_IDLE);
  assign o_ps2_clk_low  = (state_q == S_INHIBIT);
  assign o_ps2_data_low = (state_q == S_INHIBIT) ? (inh_cnt_q == INH_LAST) :
                          (((state_q == S_RELEASE) || (state_q == S_SEND)) && data_low_q && !timeout);
endmodule

// File: tb/tb_ps2_writer.sv
// Bench for ps2_writer: a PS/2 keyboard model clocks frames out of the DUT, a scoreboard
// compares each finished transfer against expectations queued when the byte was issued.
module tb_ps2_writer;
  localparam int M_ACK = 0, M_NOACK = 1, M_NOCLK = 2;
  localparam int INH = 20, TMO = 4000;

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic i_data_valid = 1'b0;
  logic o_ready, o_busy, o_done, o_error, o_ps2_clk_low, o_ps2_data_low;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_ln, ps2_data_ln;

  assign ps2_clk_ln  = !(o_ps2_clk_low || dev_clk_low);
  assign ps2_data_ln = !(o_ps2_data_low || dev_data_low);

  ps2_writer #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .i_ps2_clk(ps2_clk_ln), .i_ps2_data(ps2_data_ln),
    .o_ps2_clk_low(o_ps2_clk_low), .o_ps2_data_low(o_ps2_data_low)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_bad = 0;
  int   n_issued = 0, n_starts = 0, n_ended = 0;
  int   dev_mode = M_ACK, edge_num = 0;
  logic dev_abort = 1'b0;
  logic cap [0:10];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic ref_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // ---------------- keyboard model ----------------
  task automatic dev_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) dev_abort = 1'b1;
    end
  endtask

  task automatic dev_frame();
    int mode = dev_mode;
    dev_abort = 1'b0;
    edge_num  = 0;
    for (int i = 0; i <= 10; i++) cap[i] = 1'bx;
    cap[0] = ps2_data_ln;
    if (mode == M_NOCLK) return;
    dev_wait(50);
    for (int k = 1; k <= 10; k++) begin
      if (dev_abort) begin dev_clk_low = 1'b0; return; end
      dev_clk_low = 1'b1;
      edge_num = k;
      dev_wait(60);
      cap[k] = ps2_data_ln;
      dev_wait(40);
      dev_clk_low = 1'b0;
      dev_wait(100);
    end
    if (dev_abort) return;
    if (mode == M_ACK) dev_data_low = 1'b1;
    dev_wait(20);
    dev_clk_low = 1'b1;
    edge_num = 11;
    dev_wait(100);
    dev_clk_low = 1'b0;
    dev_wait(30);
    dev_data_low = 1'b0;
  endtask

  initial begin : device
    logic prev_cl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && prev_cl && !o_ps2_clk_low && o_ps2_data_low) dev_frame();
      prev_cl = o_ps2_clk_low;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic mon_prev_cl = 1'b0, last_dl = 1'b0, meas_last = 1'b0;
    int inh_len = 0, inh_dl = 0, meas_inh = 0, meas_dl = 0, rel_cyc = 0;
    logic [7:0] got_byte;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_cl = 1'b0;
        continue;
      end
      if (o_ps2_clk_low) begin
        if (!mon_prev_cl) begin
          n_starts++;
          inh_len = 0;
          inh_dl  = 0;
        end
        inh_len++;
        inh_dl += int'(o_ps2_data_low);
        last_dl = o_ps2_data_low;
      end else if (mon_prev_cl) begin
        rel_cyc   = cyc;
        meas_inh  = inh_len;
        meas_dl   = inh_dl;
        meas_last = last_dl;
      end
      mon_prev_cl = o_ps2_clk_low;
      if (o_done || o_error) begin
        chk("done_error_exclusive", 32'(o_done & o_error), 0);
        chk("lines_released_at_end", {o_ps2_clk_low, o_ps2_data_low}, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: done=%0b error=%0b, required no completion", o_done, o_error);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_is_done", 32'(o_done), 32'(e.mode == M_ACK));
          chk("inhibit_len", meas_inh, INH);
          chk("inhibit_data_low_cycles", meas_dl, 1);
          chk("inhibit_last_data_low", 32'(meas_last), 1);
          if (e.mode == M_NOCLK) begin
            chk("timeout_latency", cyc - rel_cyc, TMO);
          end else begin
            for (int i = 0; i < 8; i++) got_byte[i] = cap[i+1];
            chk("start_bit", 32'(cap[0]), 0);
            chk("data_byte", 32'(got_byte), 32'(e.data));
            chk("parity_bit", 32'(cap[9]), 32'(ref_parity(e.data)));
            chk("stop_bit", 32'(cap[10]), 1);
          end
        end
        n_ended++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_xfer(input logic [7:0] d, input int mode, input bit push);
    exp_t e;
    int i = 0;
    while (!o_ready && i < 8000) begin @(negedge clk); i++; end
    chk("ready_before_issue", 32'(o_ready), 1);
    dev_mode = mode;
    if (push) begin
      e.data = d;
      e.mode = mode;
      exp_q.push_back(e);
    end
    n_issued++;
    i_data = d;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_during_xfer", {o_busy, o_ready}, 2'b10);
  endtask

  task automatic wait_end();
    int start = n_ended;
    int i = 0;
    while (n_ended == start && i < 8000) begin @(negedge clk); i++; end
    if (n_ended == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL transfer_end_timeout: no done/error within %0d cycles", i);
    end
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    start_xfer(d, mode, 1'b1);
    wait_end();
  endtask

  initial begin : main
    int i;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done_error", {o_done, o_error}, 0);
    chk("rst_lines", {o_ps2_clk_low, o_ps2_data_low}, 0);
    rst = 1'b0;
    @(negedge clk);

    send(8'hED, M_ACK);
    send(8'hF4, M_ACK);
    send(8'h00, M_ACK);
    for (int k = 0; k < 6; k++) send(8'($urandom_range(0, 255)), M_ACK);
    send(8'($urandom_range(0, 255)), M_NOACK);
    send(8'($urandom_range(0, 255)), M_NOCLK);

    // request while busy must be dropped
    start_xfer(8'hFF, M_ACK, 1'b1);
    repeat (500) @(negedge clk);
    i_data = 8'h55;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    wait_end();
    repeat (300) @(negedge clk);
    chk("no_queued_request", n_starts, n_issued);
    chk("ready_after_ignore", 32'(o_ready), 1);

    // async reset in the middle of the data bits
    start_xfer(8'h00, M_ACK, 1'b0);
    i = 0;
    while (edge_num != 5 && i < 4000) begin @(negedge clk); i++; end
    chk("reached_edge5", edge_num, 5);
    repeat (10) @(negedge clk);
    chk("data_low_before_rst", 32'(o_ps2_data_low), 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_lines", {o_ps2_clk_low, o_ps2_data_low}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {o_ready, o_busy}, 2'b10);
    repeat (300) @(negedge clk);

    send(8'hA5, M_ACK);
    repeat (50) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("starts_match_issued", n_starts, n_issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
